// File: rtl/multicycle_addsub.sv
// Digit-serial adder/subtractor: WIDTH bits in WIDTH/DIGIT cycles behind a start/ready/valid handshake.
// Optional build macro MCADD_SATURATE_EN clamps the result to the signed limit on signed overflow.
module multicycle_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Handshake: start is taken on a rising edge while ready=1; valid pulses for
  // exactly one cycle when result and flags are final; start in RUN is ignored.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic             valid_q, valid_d;

  logic [DIGIT-1:0] a_k, b_k;
  logic [DIGIT:0]   dsum;
  logic             c_msb;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    valid_d  = 1'b0;
    a_k      = a_q[cnt_q*DIGIT +: DIGIT];
    b_k      = b_q[cnt_q*DIGIT +: DIGIT];
    dsum     = {1'b0, a_k} + {1'b0, b_k} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit recovered from that bit's sum and operand bits.
    c_msb    = a_k[DIGIT-1] ^ b_k[DIGIT-1] ^ dsum[DIGIT-1];
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d = dsum[DIGIT];
          ovf_d  = c_msb ^ dsum[DIGIT];
`ifdef MCADD_SATURATE_EN
          if (ovf_d) begin
            result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
          end
`else
`endif
          zero_d  = (result_d == '0);
          neg_d   = result_d[WIDTH-1];
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
    end
  end

  assign ready    = (state_q != S_RUN);
  assign valid    = valid_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Scoreboard bench for multicycle_addsub (WIDTH=16, DIGIT=4); honours MCADD_SATURATE_EN.
module tb_multicycle_addsub;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic         clk, rst_n, start, sub, cin;
  logic [W-1:0] a, b;
  logic         ready, valid, cout, overflow, zero, negative;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W+3:0] exp_q[$];
  int           acc_q[$];
  logic [W+3:0] mon_exp;
  int           mon_acc;

  multicycle_addsub #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
    .ready(ready), .valid(valid), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic for carry and signed range for overflow.
  function automatic logic [W+3:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms, input logic mc);
    logic [W-1:0] bp;
    logic         c0, mco, mov;
    logic [W-1:0] r;
    int           us, ss;
    bp  = ms ? ~mb : mb;
    c0  = mc ^ ms;
    us  = int'(ma) + int'(bp) + int'(c0);
    ss  = int'($signed(ma)) + int'($signed(bp)) + int'(c0);
    mco = (us > 65535);
    mov = (ss > 32767) || (ss < -32768);
    r   = us[W-1:0];
`ifdef MCADD_SATURATE_EN
    if (mov) r = ma[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {r, mco, mov, (r == '0), r[W-1]};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", {31'd0, valid}, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_acc = acc_q.pop_front();
        check_eq("result_flags", {12'd0, result, cout, overflow, zero, negative}, {12'd0, mon_exp});
        check_eq("latency", cyc - mon_acc, N);
      end
    end
  end

  // driver tasks
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic ts, input logic tc);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check_eq("ready_timeout", {31'd0, ready}, 32'd1);
      return;
    end
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(ta, tb, ts, tc));
    #1;
    acc_q.push_back(cyc);
    start = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic tc, input logic [W-1:0] er,
                          input logic ec, input logic eo, input logic ez, input logic en);
    int t = 0;
    do_op(ta, tb, ts, tc);
    do begin
      @(negedge clk);
      t++;
    end while (!valid && t < 20);
    check_eq({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check_eq({tag, "_result"}, {16'd0, result}, {16'd0, er});
    check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    check_eq({tag, "_neg"}, {31'd0, negative}, {31'd0, en});
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #12;
    check_eq("rst_result", {16'd0, result}, 32'd0);
    check_eq("rst_flags", {28'd0, cout, overflow, zero, negative}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MCADD_SATURATE_EN
    directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    directed("sub_zero", 16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef MCADD_SATURATE_EN
    directed("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    directed("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directed("cin_add", 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
    directed("bin_sub", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // start held high: only operands at the accept edges count
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check_eq("b2b_ready", {31'd0, ready}, {31'd0, (k % 5 == 0)});
      a = W'($urandom_range(0, 65535));
      b = W'($urandom_range(0, 65535));
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      start = 1'b1;
      @(posedge clk);
      if (k % 5 == 0) begin
        exp_q.push_back(model(a, b, sub, cin));
        #1;
        acc_q.push_back(cyc);
      end
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-RUN
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_result", {16'd0, result}, 32'd0);
    check_eq("arst_flags", {28'd0, cout, overflow, zero, negative}, 32'd0);
    check_eq("arst_valid", {31'd0, valid}, 32'd0);
    check_eq("arst_ready", {31'd0, ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      check_eq("arst_hold_valid", {31'd0, valid}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("post_rst_no_valid", {31'd0, valid}, 32'd0);
    end
    directed("post_rst", 16'h0100, 16'h00FF, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      do_op(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_addsub.md
# multicycle_addsub

Parametrised multi-cycle signed/unsigned adder-subtractor. It processes a WIDTH-bit operation DIGIT bits per clock, carrying between digits in a register, and reports carry, signed overflow, zero and negative flags. It succeeds the single-bit NAND full adder with overflow as the datapath arithmetic unit for narrow-area builds. It sits behind a start/ready/valid handshake so a sequencer can issue one operation at a time.

## Interface
- WIDTH, 16: operand/result width; must be ≥ 2.
- DIGIT, 4: bits processed per cycle; WIDTH % DIGIT must be 0. N = WIDTH/DIGIT.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted on a rising edge when ready=1
- a  input  WIDTH  operand A, sampled on acceptance
- b  input  WIDTH  operand B, sampled on acceptance
- sub  input  1  0: A+B+cin; 1: A−B−cin; sampled on acceptance
- cin  input  1  carry-in (add) / borrow-in (sub); sampled on acceptance
- ready  output  1  high in IDLE and DONE
- valid  output  1  one-cycle pulse: result/flags are final
- result  output  WIDTH  sum/difference
- cout  output  1  carry out of the MSB (sub: 1 = no borrow)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE → RUN when start is high at an edge.
  - Latch a and ~b-if-sub (else b).
  - Carry register = cin XOR sub.
  - Digit counter = 0.
- RUN: each edge computes digit k = counter.
  - result[k*DIGIT +: DIGIT] = A_k + B'_k + carry; the carry register takes the digit carry-out.
  - On the last digit (k = N−1), also capture the carry into the MSB, and set cout and overflow.
  - Go to DONE.
- DONE lasts one cycle: valid=1, ready=1.
  - start high → RUN with new operands (back-to-back).
  - Otherwise → IDLE.
- start while in RUN is ignored. No queuing and no error flag.
- zero and negative are evaluated on the final (possibly saturated) result. They update on the same edge as cout and overflow.
- result and flags hold their values from DONE until the first RUN edge of the next accepted operation. While in RUN, result holds partial digits and is not valid.
- Unsigned overflow is reported only via cout. Signed overflow is reported via overflow. Both flags are always computed regardless of the caller's interpretation.

## Timing
- Start accepted at edge E0. Digits 0..N−1 are written at edges E1..EN. valid is high from EN to EN+1.
- Latency is N+1 edges from acceptance to valid falling.
- Issue interval is N+1 cycles minimum (start during DONE).
- ready is decoded from state (combinational). valid and all data outputs are registered.
- Reset, asynchronous and at any time including mid-RUN:
  - state = IDLE; result, cout, overflow, zero, negative, valid = 0; ready = 1.
  - Any in-flight operation is discarded with no valid pulse.
- Reset release: the first edge with rst_n=1 may accept start.

## Configuration
- MCADD_SATURATE_EN defined: on signed overflow at the final digit, result is replaced by the signed limit.
  - A sign 0 → 0111…1.
  - A sign 1 → 1000…0.
  - overflow and cout still report the raw condition.
  - zero and negative reflect the saturated value.
- MCADD_SATURATE_EN undefined: result is the raw two's-complement wrap. No saturation logic is built.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 (N=4).
- 0x7FFF + 0x0001, sub=0, cin=0 → valid at E4.
  - Unsaturated: result=0x8000, overflow=1, cout=0, negative=1.
  - With MCADD_SATURATE_EN: result=0x7FFF, negative=0.
- 0x0005 − 0x0005, sub=1 → result=0x0000, zero=1, cout=1, overflow=0.
  - Then 0x8000 − 0x0001 → 0x7FFF, overflow=1, cout=1.
  - With MCADD_SATURATE_EN: 0x8000 − 0x0001 gives 0x8000.
- 0xFFFF + 0x0001 → result=0x0000, cout=1, overflow=0, zero=1.
  - Then 0x1234 + 0x0000 with cin=1 → 0x1235.
  - Then 0x0010 − 0x0001 with sub=1, cin=1 → 0x000E.
- Hold start high continuously, changing operands each cycle:
  - Only operands at E0 and at each DONE cycle are used.
  - valid pulses every 5 cycles.
  - ready=0 throughout RUN.
- Assert rst_n=0 at E2 of an operation:
  - All outputs = 0 and ready=1 immediately (asynchronously).
  - No valid pulse follows.
  - The next operation after release produces the correct result.
- Random operands × sub × cin, ≥10k operations, compared against a reference model of a+b+cin / a−b−cin with the flag equations above.
